// File: rtl/otter_mem_loader_pkg.sv
// rtl/otter_mem_loader_pkg.sv - shared types and constants for the OTTER memory loader
package otter_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_DONE,
    S_ERROR
  } loader_state_t;

  // States in which a load is underway.
  function automatic logic is_active(loader_state_t s);
    return (s == S_COLLECT) || (s == S_WRITE) || (s == S_READ) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/otter_mem_loader_if.sv
// rtl/otter_mem_loader_if.sv - byte stream and word-memory bus between host, loader and memory
interface otter_mem_loader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic [7:0]            BYTE_IN;
  logic                  BYTE_VALID;
  logic                  BYTE_READY;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [31:0]           MEM_DIN;
  logic                  MEM_WE;
  logic [31:0]           MEM_DOUT;

  modport master (
    input  BYTE_IN, BYTE_VALID, MEM_DOUT,
    output BYTE_READY, MEM_ADDR, MEM_DIN, MEM_WE
  );

  modport slave (
    output BYTE_IN, BYTE_VALID, MEM_DOUT,
    input  BYTE_READY, MEM_ADDR, MEM_DIN, MEM_WE
  );

endinterface

// File: rtl/otter_mem_loader_packer.sv
// rtl/otter_mem_loader_packer.sv - packs a byte stream little-endian into 32-bit words
module otter_byte_packer
  import otter_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              full
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_word;

  // Shifting in from the top lands the first byte in lane 0 after the fourth push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (clr) begin
      r_idx <= '0;
    end else if (push) begin
      r_word <= {byte_in, r_word[WORD_W-1:8]};
      r_idx  <= r_idx + 1'b1;
    end
  end

  assign word_out = r_word;
  assign full     = push && (r_idx == LAST_IDX);

endmodule

// File: rtl/otter_mem_loader.sv
// rtl/otter_mem_loader.sv - loads a byte stream into OTTER memory with per-word readback verify
module otter_mem_loader
  import otter_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LD_START,
  input  logic [ADDR_WIDTH:0]   LD_LEN,
  otter_mem_loader_if.master    bus,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  CPU_HOLD
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_t         r_state;
  loader_state_t         w_next;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  r_hold;

  logic                  w_accept;
  logic                  w_push;
  logic                  w_full;
  logic                  w_clr;
  logic                  w_addr_inc;
  logic                  w_last;
  logic                  w_match;
  logic [WORD_W-1:0]     w_word;

  assign w_accept = LD_START &&
                    ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_push   = bus.BYTE_VALID && (r_state == S_COLLECT);
  assign w_last   = ({1'b0, r_addr} == (r_len - 1'b1));
  assign w_match  = (bus.MEM_DOUT == w_word);

  otter_byte_packer u_packer (
    .clk      (CLK),
    .rst      (RST),
    .clr      (w_clr),
    .push     (w_push),
    .byte_in  (bus.BYTE_IN),
    .word_out (w_word),
    .full     (w_full)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_clr      = 1'b0;
    w_addr_inc = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_accept) begin
          w_clr = 1'b1;
          if (LD_LEN == '0)          w_next = S_DONE;
          else if (LD_LEN > MAX_LEN) w_next = S_ERROR;
          else                       w_next = S_COLLECT;
        end
      end
      S_COLLECT: if (w_full) w_next = S_WRITE;
      S_WRITE:   w_next = S_READ;
      S_READ:    w_next = S_CHECK;
      S_CHECK: begin
        if (!w_match) begin
          w_next = S_ERROR;
        end else if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next     = S_COLLECT;
          w_clr      = 1'b1;
          w_addr_inc = 1'b1;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_len  <= '0;
      r_addr <= '0;
      r_we   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_hold <= 1'b0;
    end else begin
      r_we   <= (w_next == S_WRITE);
      r_busy <= is_active(w_next);
      r_done <= (w_next == S_DONE);
      r_err  <= (w_next == S_ERROR);
      r_hold <= is_active(w_next) || (w_next == S_ERROR);
      if (w_accept) begin
        r_len  <= LD_LEN;
        r_addr <= '0;
      end else if (w_addr_inc) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign bus.BYTE_READY = (r_state == S_COLLECT);
  assign bus.MEM_ADDR   = r_addr;
  assign bus.MEM_DIN    = w_word;
  assign bus.MEM_WE     = r_we;
  assign BUSY           = r_busy;
  assign DONE           = r_done;
  assign ERR            = r_err;
  assign CPU_HOLD       = r_hold;

endmodule

// File: tb/tb_otter_mem_loader.sv
// tb/tb_otter_mem_loader.sv - self-checking bench for otter_mem_loader with a 1-cycle memory model
module tb_otter_mem_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int len;
    bit fixed;
    int gap;
    bit corrupt;
    bit exp_done;
    bit exp_err;
    int exp_we;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          LD_START = 1'b0;
  logic [AW:0]   LD_LEN = '0;
  logic          BUSY, DONE, ERR, CPU_HOLD;

  otter_mem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  otter_mem_loader #(.ADDR_WIDTH(AW)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LD_START (LD_START),
    .LD_LEN   (LD_LEN),
    .bus      (bus.master),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR),
    .CPU_HOLD (CPU_HOLD)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read memory model plus event counters.
  logic [31:0] mem [DEPTH];
  logic        corrupt  = 1'b0;
  logic        fill_req = 1'b0;
  int          we_cnt = 0, xfer_cnt = 0, rdy_cnt = 0;

  function automatic logic [31:0] sentinel(int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  always @(posedge CLK) begin
    if (fill_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= sentinel(i);
    end else if (bus.MEM_WE) begin
      mem[bus.MEM_ADDR] <= bus.MEM_DIN;
    end
    bus.MEM_DOUT <= mem[bus.MEM_ADDR] ^ {31'b0, corrupt};
    if (bus.MEM_WE) we_cnt <= we_cnt + 1;
    if (bus.BYTE_VALID && bus.BYTE_READY) xfer_cnt <= xfer_cnt + 1;
    if (bus.BYTE_READY) rdy_cnt <= rdy_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] word_of(input byte_q_t b, input int i);
    return {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic pulse_fill();
    @(negedge CLK); fill_req = 1'b1;
    @(negedge CLK); fill_req = 1'b0;
  endtask

  task automatic start(input int len);
    @(negedge CLK);
    LD_LEN   = (AW+1)'(len);
    LD_START = 1'b1;
    @(negedge CLK);
    LD_START = 1'b0;
  endtask

  task automatic feed(input byte_q_t b, input int gap_max, input int max_cyc, output int sent);
    int cyc = 0;
    int gap = 0;
    sent = 0;
    while (sent < b.size() && cyc < max_cyc) begin
      @(negedge CLK);
      cyc++;
      if (gap > 0) begin
        bus.BYTE_VALID = 1'b0;
        gap--;
      end else begin
        bus.BYTE_VALID = 1'b1;
        bus.BYTE_IN    = b[sent];
        if (bus.BYTE_READY) begin
          sent++;
          if (gap_max > 0) gap = $urandom_range(0, gap_max);
        end
      end
    end
    @(negedge CLK);
    bus.BYTE_VALID = 1'b0;
  endtask

  task automatic wait_end(input int limit, output int cyc);
    cyc = 0;
    while (!(DONE || ERR) && cyc < limit) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input byte_q_t b);
    int we0, x0, r0, sent, lat, bad, exp_x;
    pulse_fill();
    corrupt = v.corrupt;
    we0 = we_cnt; x0 = xfer_cnt; r0 = rdy_cnt;
    start(v.len);
    if (b.size() > 0) feed(b, v.gap, 32 * v.len + 100, sent);
    wait_end(50, lat);
    exp_x = (v.len > DEPTH) ? 0 : 4 * v.len;
    check({tag, "_done"}, DONE, v.exp_done);
    check({tag, "_err"}, ERR, v.exp_err);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_hold"}, CPU_HOLD, v.exp_err);
    check({tag, "_we_pulses"}, 32'(we_cnt - we0), 32'(v.exp_we));
    check({tag, "_bytes_taken"}, 32'(xfer_cnt - x0), 32'(exp_x));
    if (v.len == 0 || v.len > DEPTH) begin
      check({tag, "_latency"}, 32'(lat), 0);
      check({tag, "_ready_cycles"}, 32'(rdy_cnt - r0), 0);
    end
    if (v.exp_done && v.len > 0) begin
      bad = 0;
      for (int i = 0; i < v.len; i++) if (mem[i] !== word_of(b, i)) bad++;
      check({tag, "_mem_bad_words"}, 32'(bad), 0);
      if (v.len < DEPTH) check({tag, "_mem_past_end"}, mem[v.len], sentinel(v.len));
    end
    corrupt = 1'b0;
  endtask

  vec_t    vecs[6];
  byte_q_t bq;
  vec_t    rv;
  int      sent_x, lat_x, we0_x;

  initial begin
    bus.BYTE_VALID = 1'b0;
    bus.BYTE_IN    = 8'h00;

    vecs[0] = '{2,    1, 0, 0, 1, 0, 2};
    vecs[1] = '{0,    0, 0, 0, 1, 0, 0};
    vecs[2] = '{1,    0, 0, 1, 0, 1, 1};
    vecs[3] = '{3,    0, 5, 0, 1, 0, 3};
    vecs[4] = '{1025, 0, 0, 0, 0, 1, 0};
    vecs[5] = '{1024, 0, 0, 0, 1, 0, 1024};

    repeat (3) @(negedge CLK);
    check("rst_ready", bus.BYTE_READY, 0);
    check("rst_we", bus.MEM_WE, 0);
    check("rst_addr", 32'(bus.MEM_ADDR), 0);
    check("rst_din", bus.MEM_DIN, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_hold", CPU_HOLD, 0);
    RST = 1'b0;

    for (int k = 0; k < 6; k++) begin
      bq.delete();
      if (vecs[k].fixed) bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      else if (vecs[k].len <= DEPTH) bq = rand_bytes(4 * vecs[k].len);
      run_vec($sformatf("vec%0d", k), vecs[k], bq);
      if (vecs[k].fixed) begin
        check("fixed_mem0", mem[0], 32'h12345678);
        check("fixed_mem1", mem[1], 32'hDEADBEEF);
      end
      if (vecs[k].corrupt) begin
        check("corrupt_mem0_written", mem[0], word_of(bq, 0));
        feed(rand_bytes(4), 0, 20, sent_x);
        check("corrupt_no_more_bytes", 32'(sent_x), 0);
        check("corrupt_hold_kept", CPU_HOLD, 1);
        check("corrupt_err_kept", ERR, 1);
      end
    end

    // Reset in the middle of the second word.
    pulse_fill();
    bq = rand_bytes(8);
    start(2);
    feed(bq[0:5], 0, 100, sent_x);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    check("midrst_ready", bus.BYTE_READY, 0);
    check("midrst_we", bus.MEM_WE, 0);
    check("midrst_addr", 32'(bus.MEM_ADDR), 0);
    check("midrst_din", bus.MEM_DIN, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_done", DONE, 0);
    check("midrst_err", ERR, 0);
    check("midrst_hold", CPU_HOLD, 0);
    RST = 1'b0;
    check("midrst_mem0", mem[0], word_of(bq, 0));
    check("midrst_mem1", mem[1], sentinel(1));
    run_vec("after_rst", '{2, 0, 0, 0, 1, 0, 2}, rand_bytes(8));

    // LD_START while busy must not restart the load.
    pulse_fill();
    bq = rand_bytes(8);
    we0_x = we_cnt;
    start(2);
    fork
      feed(bq, 0, 200, sent_x);
      begin
        repeat (3) @(negedge CLK);
        LD_LEN = '0; LD_START = 1'b1;
        @(negedge CLK); LD_START = 1'b0;
      end
    join
    wait_end(50, lat_x);
    check("busy_start_done", DONE, 1);
    check("busy_start_we", 32'(we_cnt - we0_x), 2);
    check("busy_start_mem0", mem[0], word_of(bq, 0));
    check("busy_start_mem1", mem[1], word_of(bq, 1));

    // Randomized loads against the reference model.
    for (int k = 0; k < 6; k++) begin
      rv.len = $urandom_range(1, 8);
      rv.fixed = 0;
      rv.gap = $urandom_range(0, 5);
      rv.corrupt = 0;
      rv.exp_done = 1;
      rv.exp_err = 0;
      rv.exp_we = rv.len;
      run_vec($sformatf("rand%0d", k), rv, rand_bytes(4 * rv.len));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
